// File: rtl/pipe_pkg.sv
// Shared ID/EX control-word layout and
// occupancy-state encodings.
package pipe_pkg;

  localparam int WB_HI        = 7;
  localparam int WB_LO        = 6;
  localparam int MEM_HI       = 5;
  localparam int MEM_LO       = 4;
  localparam int EX_HI        = 3;
  localparam int EX_LO        = 0;
  localparam int EX_ALU_SRC   = 3;
  localparam int EX_ALU_OP_HI = 2;
  localparam int EX_ALU_OP_LO = 1;
  localparam int EX_REG_DST   = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline storage slot: packed control+data
// with load enable and synchronous clear.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_q;

  // hold the slot, clearing or loading on demand
  always_ff @(posedge clk_i) begin
    if (clr_i)
      r_q <= '0;
    else if (ld_i)
      r_q <= d_i;
  end

  assign q_o = r_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX stage register: valid/ready handshake,
// optional skid slot, flush and NOP bubbles.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 8,
  parameter int SKID_EN    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [CTRL_W-1:0]     ctrl_i,
  input  logic [DATA_W-1:0]     data1_i,
  input  logic [DATA_W-1:0]     data2_i,
  input  logic [DATA_W-1:0]     immd_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rt_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CTRL_W-1:0]     ctrl_o,
  output logic [DATA_W-1:0]     data1_o,
  output logic [DATA_W-1:0]     data2_o,
  output logic [DATA_W-1:0]     immd_o,
  output logic [REG_ADDR_W-1:0] rs_o,
  output logic [REG_ADDR_W-1:0] rt_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [1:0]            count_o
);

  localparam int PW =
    CTRL_W + 3*DATA_W + 3*REG_ADDR_W;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_out_valid;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_pop;
  logic            w_ld_main;
  logic            w_ld_skid;
  logic            w_sel_skid;
  logic [PW-1:0]   w_in_pack;
  logic [PW-1:0]   w_main_d;
  logic [PW-1:0]   w_main_q;
  logic [PW-1:0]   w_skid_q;
  logic [CTRL_W-1:0] w_ctrl_q;

  assign w_out_valid = (r_state != ST_EMPTY);

  generate
    if (SKID_EN != 0) begin : g_rdy_reg
      assign w_in_ready = (r_state != ST_TWO);
    end else begin : g_rdy_pass
      assign w_in_ready = !w_out_valid | out_ready_i;
    end
  endgenerate

  assign w_accept = in_valid_i & w_in_ready;
  assign w_pop    = w_out_valid & out_ready_i;

  assign w_in_pack = {ctrl_i, data1_i, data2_i,
                      immd_i, rs_i, rt_i, rd_i};

  // occupancy state register
  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_state <= ST_EMPTY;
    else
      r_state <= w_state_nxt;
  end

  // next occupancy; flush drops everything
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY:
          if (w_accept) w_state_nxt = ST_ONE;
        ST_ONE:
          if (w_accept && !w_pop)
            w_state_nxt = (SKID_EN != 0) ? ST_TWO
                                         : ST_ONE;
          else if (!w_accept && w_pop)
            w_state_nxt = ST_EMPTY;
        ST_TWO:
          if (w_pop) w_state_nxt = ST_ONE;
        default:
          w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // slot load controls for the current move
  always_comb begin
    w_ld_main  = 1'b0;
    w_ld_skid  = 1'b0;
    w_sel_skid = 1'b0;
    if (!flush_i) begin
      case (r_state)
        ST_EMPTY: w_ld_main = w_accept;
        ST_ONE: begin
          w_ld_main = w_accept & w_pop;
          w_ld_skid = w_accept & ~w_pop;
        end
        ST_TWO: begin
          w_ld_main  = w_pop;
          w_sel_skid = 1'b1;
        end
        default: w_ld_main = 1'b0;
      endcase
    end
  end

  assign w_main_d = w_sel_skid ? w_skid_q
                               : w_in_pack;

  pipe_entry #(.W(PW)) u_main (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .ld_i  (w_ld_main),
    .d_i   (w_main_d),
    .q_o   (w_main_q)
  );

  generate
    if (SKID_EN != 0) begin : g_skid
      pipe_entry #(.W(PW)) u_skid (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .ld_i  (w_ld_skid),
        .d_i   (w_in_pack),
        .q_o   (w_skid_q)
      );
    end else begin : g_noskid
      assign w_skid_q = '0;
    end
  endgenerate

  assign {w_ctrl_q, data1_o, data2_o, immd_o,
          rs_o, rt_o, rd_o} = w_main_q;

  assign ctrl_o      = w_out_valid ? w_ctrl_q : '0;
  assign out_valid_o = w_out_valid;
  assign in_ready_o  = w_in_ready;
  assign count_o     = r_state;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg in skid
// and pass-through configurations.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        va, ra, vb, rb;
  logic [7:0]  ctrl;
  logic [31:0] d1, d2, imm;
  logic [4:0]  rs, rt, rd;

  logic        a_rdy, a_vld;
  logic [7:0]  a_ctrl;
  logic [31:0] a_d1, a_d2, a_imm;
  logic [4:0]  a_rs, a_rt, a_rd;
  logic [1:0]  a_cnt;

  logic        b_rdy, b_vld;
  logic [7:0]  b_ctrl;
  logic [31:0] b_d1, b_d2, b_imm;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [1:0]  b_cnt;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.SKID_EN(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(va), .in_ready_o(a_rdy),
    .ctrl_i(ctrl), .data1_i(d1), .data2_i(d2),
    .immd_i(imm), .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .out_valid_o(a_vld), .out_ready_i(ra),
    .ctrl_o(a_ctrl), .data1_o(a_d1),
    .data2_o(a_d2), .immd_o(a_imm),
    .rs_o(a_rs), .rt_o(a_rt), .rd_o(a_rd),
    .count_o(a_cnt)
  );

  id_ex_pipe_reg #(.SKID_EN(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(vb), .in_ready_o(b_rdy),
    .ctrl_i(ctrl), .data1_i(d1), .data2_i(d2),
    .immd_i(imm), .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .out_valid_o(b_vld), .out_ready_i(rb),
    .ctrl_o(b_ctrl), .data1_o(b_d1),
    .data2_o(b_d2), .immd_o(b_imm),
    .rs_o(b_rs), .rt_o(b_rt), .rd_o(b_rd),
    .count_o(b_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    va = $urandom; ra = $urandom;
    vb = $urandom; rb = $urandom;
    ctrl = $urandom; d1 = $urandom;
    d2 = $urandom; imm = $urandom;
    rs = $urandom; rt = $urandom; rd = $urandom;
    repeat (2) @(negedge clk);

    chk("rst_a_vld", a_vld, 0);
    chk("rst_a_ctrl", a_ctrl, 0);
    chk("rst_a_d1", a_d1, 0);
    chk("rst_a_d2", a_d2, 0);
    chk("rst_a_imm", a_imm, 0);
    chk("rst_a_rs", a_rs, 0);
    chk("rst_a_rt", a_rt, 0);
    chk("rst_a_rd", a_rd, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_rdy", a_rdy, 1);
    chk("rst_b_vld", b_vld, 0);
    chk("rst_b_ctrl", b_ctrl, 0);
    chk("rst_b_d1", b_d1, 0);
    chk("rst_b_d2", b_d2, 0);
    chk("rst_b_imm", b_imm, 0);
    chk("rst_b_rs", b_rs, 0);
    chk("rst_b_rt", b_rt, 0);
    chk("rst_b_rd", b_rd, 0);
    chk("rst_b_cnt", b_cnt, 0);
    chk("rst_b_rdy", b_rdy, 1);

    rst = 1'b0; va = 1'b0; vb = 1'b0;
    ra = 1'b1; rb = 1'b1;
    ctrl = 8'hC5; d2 = 32'h0; imm = 32'h0;
    rs = 5'd1; rt = 5'd2; rd = 5'd3;
    @(negedge clk);

    // streaming, one per cycle
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        chk("str_vld", a_vld, 1);
        chk("str_d1", a_d1, 64'(32'h10 + i - 1));
        chk("str_ctrl", a_ctrl, 8'hC5);
        chk("str_cnt", a_cnt, 1);
        chk("str_rdy", a_rdy, 1);
      end
      if (i < 8) begin
        va = 1'b1;
        d1 = 32'(32'h10 + i);
      end else begin
        va = 1'b0;
      end
      @(negedge clk);
    end
    chk("bub_vld", a_vld, 0);
    chk("bub_ctrl", a_ctrl, 0);
    chk("bub_cnt", a_cnt, 0);

    // stall and skid
    va = 1'b1; d1 = 32'hA0; rd = 5'h1D;
    @(negedge clk);
    chk("stl_a0", a_d1, 32'hA0);
    chk("stl_rd", a_rd, 5'h1D);
    chk("stl_rdy1", a_rdy, 1);
    d1 = 32'hA1; rd = 5'h03; ra = 1'b0;
    @(negedge clk);
    chk("stl_cnt2", a_cnt, 2);
    chk("stl_rdy0", a_rdy, 0);
    chk("stl_hold", a_d1, 32'hA0);
    d1 = 32'hA2;
    @(negedge clk);
    chk("stl_cnt2b", a_cnt, 2);
    chk("stl_hold2", a_d1, 32'hA0);
    chk("stl_hrd", a_rd, 5'h1D);
    ra = 1'b1;
    @(negedge clk);
    chk("rel_a1", a_d1, 32'hA1);
    chk("rel_rdy", a_rdy, 1);
    chk("rel_cnt", a_cnt, 1);
    @(negedge clk);
    chk("rel_a2", a_d1, 32'hA2);
    chk("rel_cnt1", a_cnt, 1);
    va = 1'b0;
    @(negedge clk);
    chk("rel_empty", a_vld, 0);
    chk("rel_cnt0", a_cnt, 0);

    // flush while full
    va = 1'b1; d1 = 32'hB0; ra = 1'b0;
    @(negedge clk);
    d1 = 32'hB1;
    @(negedge clk);
    chk("fl_cnt2", a_cnt, 2);
    flush = 1'b1; d1 = 32'hFF;
    chk("fl_rdy", a_rdy, 0);
    @(negedge clk);
    chk("fl_vld", a_vld, 0);
    chk("fl_ctrl", a_ctrl, 0);
    chk("fl_cnt", a_cnt, 0);
    chk("fl_rdy1", a_rdy, 1);
    flush = 1'b0; va = 1'b0;
    @(negedge clk);
    chk("fl_vld2", a_vld, 0);
    n_chk++;
    assert (a_d1 !== 32'hFF) else begin
      n_err++;
      $error("FAIL fl_noff: got %0h want not ff",
             a_d1);
    end

    // reset mid-stall
    va = 1'b1; d1 = 32'hD0; ra = 1'b0;
    @(negedge clk);
    d1 = 32'hD1;
    @(negedge clk);
    chk("rs_cnt2", a_cnt, 2);
    rst = 1'b1; va = 1'b0;
    @(negedge clk);
    chk("rs_vld", a_vld, 0);
    chk("rs_cnt", a_cnt, 0);
    chk("rs_rdy", a_rdy, 1);
    chk("rs_d1", a_d1, 0);
    rst = 1'b0; ra = 1'b1;
    @(negedge clk);

    // pass-through mode stall
    vb = 1'b1; d1 = 32'hC0; rb = 1'b1;
    @(negedge clk);
    chk("b_c0", b_d1, 32'hC0);
    chk("b_cnt1", b_cnt, 1);
    chk("b_ctrl", b_ctrl, 8'hC5);
    d1 = 32'hC1; rb = 1'b0;
    #1;
    chk("b_rdy0", b_rdy, 0);
    rb = 1'b1;
    #1;
    chk("b_rdy1", b_rdy, 1);
    rb = 1'b0;
    @(negedge clk);
    chk("b_hold", b_d1, 32'hC0);
    chk("b_cnt1b", b_cnt, 1);
    rb = 1'b1;
    @(negedge clk);
    chk("b_c1", b_d1, 32'hC1);
    chk("b_cnt1c", b_cnt, 1);
    vb = 1'b0;
    @(negedge clk);
    chk("b_empty", b_vld, 0);
    chk("b_cnt0", b_cnt, 0);
    chk("b_bub", b_ctrl, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID/EX pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and bubble insertion. It sits between the decode stage and the execute stage. It replaces the fixed-width, always-advancing ID/EX latch so that the pipeline can stall on back-pressure and squash on branch or exception without losing or duplicating an instruction. Control bits leaving the stage are forced to zero whenever no valid instruction is presented, so downstream stages see a clean NOP.

## Interface
Parameters:
- `DATA_W`, default 32: width of each register operand and the immediate.
- `REG_ADDR_W`, default 5: width of the rs/rt/rd register addresses.
- `CTRL_W`, default 8: width of the packed control word (WB, MEM, EX fields).
- `SKID_EN`, default 1: 1 gives two entries with a registered `in_ready_o`; 0 gives one entry with a pass-through ready.

Ports:
- `clk_i`, in, 1: sole clock; all state updates on its rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `flush_i`, in, 1: squash all held entries and any same-cycle input.
- `in_valid_i`, in, 1: decode presents an instruction.
- `in_ready_o`, out, 1: stage can accept this cycle.
- `ctrl_i`, in, `CTRL_W`: packed control word.
- `data1_i`, `data2_i`, `immd_i`, in, `DATA_W`: operands and immediate.
- `rs_i`, `rt_i`, `rd_i`, in, `REG_ADDR_W`: register addresses.
- `out_valid_o`, out, 1: execute has a valid instruction.
- `out_ready_i`, in, 1: execute consumes this cycle.
- `ctrl_o`, `data1_o`, `data2_o`, `immd_o`, `rs_o`, `rt_o`, `rd_o`, out: the held fields, each the same width as its input.
- `count_o`, out, 2: occupancy, 0 to 2.

## Operation
- Handshake events:
  - accept = `in_valid_i & in_ready_o`.
  - pop = `out_valid_o & out_ready_i`.
- Storage: a main entry drives the outputs; a skid entry exists only when `SKID_EN`=1.
- State machine (`SKID_EN`=1): EMPTY, ONE, TWO.
  - EMPTY: accept moves to ONE, input loaded into main.
  - ONE, accept and no pop: move to TWO, input loaded into skid.
  - ONE, accept and pop: stay in ONE, input loaded into main.
  - ONE, pop only: move to EMPTY.
  - TWO: `in_ready_o`=0. Pop moves to ONE, with skid copied to main.
- `in_ready_o` (`SKID_EN`=1) = state != TWO. It is a registered signal, with no combinational path from `out_ready_i`.
- `SKID_EN`=0: single entry; `in_ready_o` = `!out_valid_o | out_ready_i`; count_o never exceeds 1.
- Flush:
  - Next state is EMPTY and both entries are invalidated.
  - Any same-cycle accept is discarded; flush has priority over accept and pop.
  - `in_ready_o` is not gated by `flush_i`.
- Bubble: while `out_valid_o`=0, `ctrl_o` = 0. The data and address outputs hold their last value; they are don't-care, but must not be X after reset.
- Data fields are captured unmodified, with no sign extension or width change.
- Reset:
  - State is EMPTY.
  - `out_valid_o`=0, `count_o`=0, and `in_ready_o`=1 (both modes).
  - `ctrl_o`, `data1_o`, `data2_o`, `immd_o`, `rs_o`, `rt_o` and `rd_o` are all 0.
  - Reset has priority over flush.

## Timing
- Latency: an instruction accepted at edge N is presented on the outputs after edge N, i.e. one cycle.
- Throughput: 1 instruction per cycle when `out_ready_i`=1 continuously, in both modes.
- Stall (`SKID_EN`=1):
  - `out_ready_i` falls in cycle k; at most one further input is accepted (into skid).
  - `in_ready_o` is low from cycle k+1 if the stage was ONE and accepted in cycle k.
- Release from TWO:
  - The first pop presents the skid entry in the next cycle.
  - `in_ready_o` returns high in that same next cycle.
- Outputs are stable while `out_valid_o`=1 and `out_ready_i`=0; no field changes until pop or flush.
- Flush in cycle k gives `out_valid_o`=0 and `ctrl_o`=0 from cycle k+1.
- Reset asserted mid-stall clears everything on the next edge.

## Structure
- Shared package `pipe_pkg` holds the control-word layout constants:
  - WB at [7:6], MEM at [5:4], EX at [3:0].
  - Within EX: ALU_SRC at bit 3, ALU_OP at [2:1], REG_DST at bit 0.
  - The package also holds the state encodings EMPTY, ONE and TWO.
- Execute-side decode of the EX field stays in the consumer, not in this block.
- One sub-module: `pipe_entry`, a width-parametrised register with load enable and synchronous clear. It is instantiated for main and, when `SKID_EN`=1, for skid. Control and data are packed into one vector per entry.

## Test plan
- Reset: hold `rst_i` for 2 cycles with random inputs. Required: `out_valid_o`=0, `ctrl_o`=0, `data1_o`=0, `count_o`=0, `in_ready_o`=1.
- Streaming: 8 back-to-back instructions with `data1_i`=0x10..0x17 and `out_ready_i`=1. Required: outputs 0x10..0x17 on consecutive cycles, each one cycle after its accept, with `count_o`=1 throughout.
- Stall and skid: send 0xA0, 0xA1, 0xA2 with `out_ready_i`=0 from the second cycle. Required:
  - 0xA1 lands in skid, `count_o`=2, `in_ready_o`=0, and 0xA2 is held off.
  - After release, the order is 0xA0, 0xA1, 0xA2, with no loss or duplicate.
- Flush while full: from TWO, assert `flush_i` together with `in_valid_i` and `data1_i`=0xFF. Required: next cycle `out_valid_o`=0, `ctrl_o`=0, `count_o`=0, and 0xFF never appears.
- Bubble: let the stage go idle after an instruction with `ctrl_i`=0xC5. Required: `ctrl_o` reads 0x00 while `out_valid_o`=0.
- `SKID_EN`=0: repeat the stall scenario. Required: `in_ready_o` follows `out_ready_i` combinationally when full, `count_o` is at most 1, and order is preserved.
